baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Programmable UART baud-tick generator, the parametrised successor to the fixed-divisor bit-rate counter. A runtime-loadable prescaler produces an oversampling tick (`os_tick`). An oversample counter divides that into bit ticks (`bit_tick`). A half-bit alignment mode places the first bit tick after a start edge in mid-bit. It feeds both the UART transmitter (bit pacing) and the receiver (start-bit alignment and mid-bit sampling).

## Interface
- `DIV_W`, 16, width of the prescaler divisor register and counter.
- `OSR`, 16, oversample ticks per bit. Must be even and ≥2. Oversample counter width is `$clog2(OSR)`.
- `RESET_DIV`, 54, divisor loaded at reset. 54 × 16 = 864 clocks/bit, i.e. 115200 baud at 100 MHz.
- `clk` in 1: sole clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable. When low, counters hold and ticks stay 0.
- `div_in` in DIV_W: new prescaler divisor, in clocks per oversample tick.
- `div_load` in 1: one-cycle strobe that loads `div_in`.
- `align` in 1: one-cycle strobe that restarts the bit phase in half-bit mode. The receiver drives it on start-edge detect.
- `os_tick` out 1: registered one-cycle pulse, once per oversample period.
- `bit_tick` out 1: registered one-cycle pulse at each bit boundary or sample point.
- `half_phase` out 1: high while the next bit tick is a half-bit tick.
- `div_q` out DIV_W: currently active divisor.

## Operation
- Effective prescale period P = `div_q` when `div_q` ≥ 1. If `div_q` = 0, P = 1.
- Prescaler `pcnt` (DIV_W bits), on each edge with `en` = 1:
  - if `pcnt` == P−1: `pcnt` ← 0, `os_tick` ← 1;
  - else: `pcnt` ← `pcnt`+1, `os_tick` ← 0.
- Oversample counter `ocnt` advances only on a prescaler wrap. Define terminal T = OSR/2−1 if `half_phase`, else OSR−1.
  - If `ocnt` == T: `ocnt` ← 0, `bit_tick` ← 1, `half_phase` ← 0.
  - Otherwise: `ocnt` ← `ocnt`+1.
  - `bit_tick` ← 0 on every cycle without a terminal wrap.
- `en` = 0:
  - `pcnt`, `ocnt` and `half_phase` hold.
  - `os_tick` and `bit_tick` ← 0.
- `align` = 1, regardless of `en`: `pcnt` ← 0, `ocnt` ← 0, `half_phase` ← 1, both ticks ← 0.
- `div_load` = 1, regardless of `en`:
  - `div_q` ← `div_in`;
  - `pcnt` ← 0, `ocnt` ← 0, both ticks ← 0;
  - `half_phase` is unchanged unless `align` is also high.
- `div_load` and `align` in the same cycle: both take effect. The new divisor is applied in half-bit mode.
- Priority: `reset` > (`div_load`/`align`) > `en` counting.
- Changing `div_in` without `div_load` has no effect.

## Timing
- Reset values:
  - `pcnt` = 0, `ocnt` = 0;
  - `os_tick` = 0, `bit_tick` = 0;
  - `half_phase` = 1, so the first bit after reset is a half bit;
  - `div_q` = `RESET_DIV`.
- With `en` = 1 from the first edge after reset release, or after `align`/`div_load`:
  - first `os_tick` is visible after edge P, then every P cycles;
  - first `bit_tick` follows (OSR/2)·P cycles after the restart;
  - later `bit_tick`s are every OSR·P cycles.
- `bit_tick` always coincides with an `os_tick` in the same cycle.
- Latency from strobe to counter clear: 1 edge. Counting resumes on the following edge.
- Reset mid-operation discards in-flight phase. Outputs take reset values on the next edge.
- Wrap-around: counters never exceed their terminal values. A `div_load` that lowers P below the current `pcnt` is safe because the load clears `pcnt`.
- No combinational paths from inputs to outputs.

## Structure
- `uart_pkg` holds:
  - defaults `UART_DIV_W` = 16, `UART_OSR` = 16, `UART_RESET_DIV` = 54;
  - a `clog2`-based width constant for the oversample counter.
- One sub-module, `uart_prescaler`. It contains the loadable `DIV_W` divider (`pcnt`, `div_q`, P = 0 clamp) and emits the raw wrap strobe.
- The top level holds `ocnt`, `half_phase` and the output registers.

## Test plan
- Reset, `en` = 1, default params → `div_q` = 54. `os_tick` every 54 cycles. First `bit_tick` at cycle 432, next at cycles 1296 and 2160. `half_phase` drops at cycle 432.
- `div_load` with `div_in` = 10 mid-count → `os_tick` 10 cycles later. `bit_tick` 160 cycles after the load, then every 160. `half_phase` stays 0.
- `align` mid-bit at P = 10 → `half_phase` = 1. `bit_tick` 80 cycles later, then every 160. No stale tick in the strobe cycle.
- `en` low for 37 cycles at `pcnt` = 5 → no ticks. After `en` returns high, the next `os_tick` arrives 5 cycles later.
- `div_in` = 0 and `div_in` = 1 loads → `os_tick` every cycle. `bit_tick` 8 cycles after the load, then every 16. Simultaneous `div_load` + `align` gives the half phase.
- `reset` asserted 3 cycles before an expected `bit_tick` → no tick. All outputs at reset values. Timing restarts from the reset release (first `bit_tick` 432 cycles later).

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared defaults and width helpers for the UART baud-tick path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DIV_W     = 16;
    localparam int UART_OSR       = 16;
    localparam int UART_RESET_DIV = 54;

    // Oversample counter width; OSR is at least 2, so this is never zero.
    function automatic int uart_ocnt_w(input int osr);
        return (osr < 2) ? 1 : $clog2(osr);
    endfunction

    localparam int UART_OCNT_W = uart_ocnt_w(UART_OSR);

endpackage
`default_nettype wire

// File: rtl/uart_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : uart_prescaler
// Brief    : Loadable clock prescaler; emits a raw one-cycle wrap strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prescaler
    import uart_pkg::*;
#(
    parameter int DIV_W     = UART_DIV_W,
    parameter int RESET_DIV = UART_RESET_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             div_load_i,
    input  logic [DIV_W-1:0] div_in_i,
    output logic [DIV_W-1:0] div_q_o,
    output logic             wrap_o
);

    logic [DIV_W-1:0] pcnt_q;
    logic [DIV_W-1:0] pcnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] w_last;
    logic             w_wrap;

    // A divisor of 0 behaves like 1: wrap on every enabled cycle.
    assign w_last = (div_q <= DIV_W'(1)) ? '0 : (div_q - DIV_W'(1));

    always_comb begin
        pcnt_d = pcnt_q;
        div_d  = div_q;
        w_wrap = 1'b0;
        if (div_load_i) begin
            div_d = div_in_i;
        end
        if (clear_i) begin
            pcnt_d = '0;
        end else if (en_i) begin
            if (pcnt_q == w_last) begin
                pcnt_d = '0;
                w_wrap = 1'b1;
            end else begin
                pcnt_d = pcnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            div_q  <= DIV_W'(RESET_DIV);
        end else begin
            pcnt_q <= pcnt_d;
            div_q  <= div_d;
        end
    end

    assign div_q_o = div_q;
    assign wrap_o  = w_wrap;

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Brief    : Programmable UART baud-tick generator with half-bit alignment.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W     = UART_DIV_W,
    parameter int OSR       = UART_OSR,
    parameter int RESET_DIV = UART_RESET_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_in_i,
    input  logic             div_load_i,
    input  logic             align_i,
    output logic             os_tick_o,
    output logic             bit_tick_o,
    output logic             half_phase_o,
    output logic [DIV_W-1:0] div_q_o
);

    localparam int              OCNT_W      = uart_ocnt_w(OSR);
    localparam logic [OCNT_W-1:0] c_FULL_TERM = OCNT_W'(OSR - 1);
    localparam logic [OCNT_W-1:0] c_HALF_TERM = OCNT_W'(OSR / 2 - 1);

    logic              w_clear;
    logic              w_wrap;
    logic [OCNT_W-1:0] w_term;

    logic [OCNT_W-1:0] ocnt_q;
    logic [OCNT_W-1:0] ocnt_d;
    logic              half_q;
    logic              half_d;
    logic              os_tick_q;
    logic              os_tick_d;
    logic              bit_tick_q;
    logic              bit_tick_d;

    assign w_clear = div_load_i | align_i;

    uart_prescaler #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en_i),
        .clear_i    (w_clear),
        .div_load_i (div_load_i),
        .div_in_i   (div_in_i),
        .div_q_o    (div_q_o),
        .wrap_o     (w_wrap)
    );

    assign w_term = half_q ? c_HALF_TERM : c_FULL_TERM;

    // Strobes win over counting; the prescaler already suppresses its wrap then.
    always_comb begin
        ocnt_d     = ocnt_q;
        half_d     = half_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        if (w_clear) begin
            ocnt_d = '0;
            if (align_i) begin
                half_d = 1'b1;
            end
        end else if (en_i && w_wrap) begin
            os_tick_d = 1'b1;
            if (ocnt_q == w_term) begin
                ocnt_d     = '0;
                bit_tick_d = 1'b1;
                half_d     = 1'b0;
            end else begin
                ocnt_d = ocnt_q + OCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ocnt_q     <= '0;
            half_q     <= 1'b1;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            ocnt_q     <= ocnt_d;
            half_q     <= half_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick_o    = os_tick_q;
    assign bit_tick_o   = bit_tick_q;
    assign half_phase_o = half_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_tick_gen
// Brief    : Directed, table-driven self-checking bench for baud_tick_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;
    import uart_pkg::*;

    localparam int DIV_W = UART_DIV_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             align;
    logic             os_tick;
    logic             bit_tick;
    logic             half_phase;
    logic [DIV_W-1:0] div_q;

    int n_cmp  = 0;
    int n_fail = 0;

    baud_tick_gen dut (
        .clk          (clk),
        .reset        (reset),
        .en_i         (en),
        .div_in_i     (div_in),
        .div_load_i   (div_load),
        .align_i      (align),
        .os_tick_o    (os_tick),
        .bit_tick_o   (bit_tick),
        .half_phase_o (half_phase),
        .div_q_o      (div_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int div;
        bit with_align;
        int exp_os;
        int exp_bit;
        int exp_period;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until the next bit_tick; times are counted in edges from the call.
    task automatic run_until_bit(input int budget, output int first_os, output int bit_at,
                                 output int coinc, output int half_before);
        first_os    = -1;
        bit_at      = -1;
        coinc       = 0;
        half_before = -1;
        for (int n = 1; n <= budget; n++) begin
            half_before = int'(half_phase);
            tick();
            if (os_tick && first_os < 0) first_os = n;
            if (bit_tick) begin
                bit_at = n;
                coinc  = int'(os_tick);
                break;
            end
        end
    endtask

    task automatic strobe(input int d, input bit ld, input bit al);
        div_in   = DIV_W'(d);
        div_load = ld;
        align    = al;
        tick();
        div_load = 1'b0;
        align    = 1'b0;
    endtask

    vec_t vecs[7];
    int   fos, bat, coi, hb, cnt;

    initial begin
        vecs[0] = '{div: 10, with_align: 1'b0, exp_os: 10, exp_bit: 160, exp_period: 160};
        vecs[1] = '{div: 10, with_align: 1'b1, exp_os: 10, exp_bit: 80,  exp_period: 160};
        vecs[2] = '{div: 0,  with_align: 1'b1, exp_os: 1,  exp_bit: 8,   exp_period: 16};
        vecs[3] = '{div: 1,  with_align: 1'b1, exp_os: 1,  exp_bit: 8,   exp_period: 16};
        vecs[4] = '{div: 1,  with_align: 1'b0, exp_os: 1,  exp_bit: 16,  exp_period: 16};
        vecs[5] = '{div: 3,  with_align: 1'b1, exp_os: 3,  exp_bit: 24,  exp_period: 48};
        vecs[6] = '{div: 54, with_align: 1'b1, exp_os: 54, exp_bit: 432, exp_period: 864};

        reset = 1'b1; en = 1'b1; div_in = '0; div_load = 1'b0; align = 1'b0;
        repeat (3) tick();
        check("rst_os_tick",  int'(os_tick), 0);
        check("rst_bit_tick", int'(bit_tick), 0);
        check("rst_half",     int'(half_phase), 1);
        check("rst_div_q",    int'(div_q), 54);
        reset = 1'b0;

        // Default divisor: bit ticks at 432, 1296, 2160 after release.
        run_until_bit(3000, fos, bat, coi, hb);
        check("def_first_os", fos, 54);
        check("def_bit1", bat, 432);
        check("def_bit1_coinc", coi, 1);
        check("def_half_before", hb, 1);
        check("def_half_after", int'(half_phase), 0);
        run_until_bit(3000, fos, bat, coi, hb);
        check("def_bit2", bat + 432, 1296);
        run_until_bit(3000, fos, bat, coi, hb);
        check("def_bit3", bat + 1296, 2160);

        // Load P=10 mid-count.
        repeat (100) tick();
        strobe(10, 1'b1, 1'b0);
        check("ld_strobe_os", int'(os_tick), 0);
        check("ld_div_q", int'(div_q), 10);
        run_until_bit(3000, fos, bat, coi, hb);
        check("ld_first_os", fos, 10);
        check("ld_bit", bat, 160);
        check("ld_half", hb, 0);
        run_until_bit(3000, fos, bat, coi, hb);
        check("ld_period", bat, 160);

        // Align exactly on the edge that would otherwise produce a bit tick.
        run_until_bit(3000, fos, bat, coi, hb);
        repeat (159) tick();
        align = 1'b1;
        tick();
        align = 1'b0;
        check("al_stale_bit", int'(bit_tick), 0);
        check("al_stale_os", int'(os_tick), 0);
        check("al_half", int'(half_phase), 1);
        run_until_bit(3000, fos, bat, coi, hb);
        check("al_bit", bat, 80);
        run_until_bit(3000, fos, bat, coi, hb);
        check("al_period", bat, 160);

        // Pause at pcnt=5 for 37 cycles.
        strobe(10, 1'b1, 1'b0);
        repeat (5) tick();
        en  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (os_tick || bit_tick) cnt++;
        end
        check("en_low_ticks", cnt, 0);
        en  = 1'b1;
        fos = -1;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (os_tick) begin
                fos = n;
                break;
            end
        end
        check("en_resume_os", fos, 5);

        // Table of load/align combinations; each entry consumes two bit ticks.
        foreach (vecs[i]) begin
            strobe(vecs[i].div, 1'b1, vecs[i].with_align);
            check($sformatf("v%0d_div_q", i), int'(div_q), vecs[i].div);
            check($sformatf("v%0d_half", i), int'(half_phase), int'(vecs[i].with_align));
            run_until_bit(3000, fos, bat, coi, hb);
            check($sformatf("v%0d_os", i), fos, vecs[i].exp_os);
            check($sformatf("v%0d_bit", i), bat, vecs[i].exp_bit);
            check($sformatf("v%0d_coinc", i), coi, 1);
            run_until_bit(3000, fos, bat, coi, hb);
            check($sformatf("v%0d_period", i), bat, vecs[i].exp_period);
        end

        // Reset three cycles before the first half-bit tick at P=54.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (429) tick();
        reset = 1'b1;
        tick();
        check("mr_bit", int'(bit_tick), 0);
        check("mr_os", int'(os_tick), 0);
        check("mr_half", int'(half_phase), 1);
        check("mr_div_q", int'(div_q), 54);
        reset = 1'b0;
        cnt = 0;
        run_until_bit(3000, fos, bat, coi, hb);
        check("mr_restart_bit", bat, 432);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
